csr_trap_sequencer: RTL and testbench
=====================================

// Module: csr_trap_sequencer
// PURPOSE
// Sits directly upstream of the CSR file and owns its single write port and single read port.
// In normal operation it passes pipeline CSR-instruction accesses straight through.
// On an exception, a taken interrupt or an MRET, it runs a multi-cycle sequence through the one write port.
// The sequence saves or restores machine trap state, then issues a one-cycle PC redirect to the fetch stage.
// PARAMETERS
// MSTATUS_IDX  4'h0          CSR file index of mstatus (MIE=bit3, MPIE=bit7, MPP=bits12:11)
// MTVEC_IDX    4'h8          CSR file index of mtvec
// MEPC_IDX     4'h9          CSR file index of mepc
// MCAUSE_IDX   4'hA          CSR file index of mcause
// MTVAL_IDX    4'hB          CSR file index of mtval
// INT_CAUSE    32'h8000000B  mcause value written for a taken interrupt (machine external)
// PORTS
// clock                 in   1   sole clock, rising edge
// reset                 in   1   synchronous, active-high
// trapRequest           in   1   exception from the pipeline, sampled only in IDLE
// trapCause             in   32  exception mcause
// trapPC                in   32  faulting PC (exception) / resume PC (interrupt)
// trapValue             in   32  mtval for the exception
// interrupt             in   1   level interrupt line
// mretRequest           in   1   MRET retiring, sampled only in IDLE
// instCsrWriteEnable    in   1   pipeline CSR-instruction write strobe
// instCsrDestination    in   4   pipeline CSR write index (destinationCSR_ encoding)
// instCsrWriteData      in   32  pipeline CSR write data
// instCsrReadSel        in   4   pipeline CSR read index
// instCsrReadData       out  32  read data returned to the pipeline (= csrReadData)
// destinationCSR        out  4   to CSR file: write index
// readCSR               out  4   to CSR file: read index
// csrWriteData          out  32  to CSR file: write data
// csrDestinationEnable  out  1   to CSR file: write strobe
// csrReadData           in   32  from CSR file: combinational read of readCSR
// busy                  out  1   stall to the pipeline, = (state != IDLE)
// redirectValid         out  1   one-cycle pulse; fetch loads redirectPC and the pipeline flushes
// redirectPC            out  32  redirect target
// BEHAVIOUR
// - Reset: state=IDLE; busy=0, redirectValid=0, redirectPC=0, csrDestinationEnable=0, all latches cleared.
// - Reset mid-sequence aborts at once with no further writes; CSR writes already made are not undone.
// - IDLE, no request: passthrough; readCSR=instCsrReadSel.
// - IDLE, no request: destinationCSR, csrWriteData and csrDestinationEnable mirror the inst* write inputs.
// - IDLE accept priority: trapRequest > mretRequest > interrupt.
// - On any accept, that cycle's inst write is suppressed (csrDestinationEnable=0).
// - On accept, latch pc/cause/value; an interrupt latches trapPC with cause INT_CAUSE.
// - Exception FSM, one state per cycle:
//   SAVE_EPC (wr mepc=pc; rd mstatus, latch)
//   -> SAVE_CAUSE (wr mcause) -> SAVE_TVAL (wr mtval; an interrupt writes 0)
//   -> SET_STATUS (wr mstatus: MPIE<=MIE, MIE<=0, MPP<=2'b11, other bits kept; rd mtvec, latch) -> REDIRECT.
// - Interrupt path: IDLE -> INT_CHECK (rd mstatus).
//   If MIE=0: return to IDLE, no writes, no redirect.
//   If MIE=1: enter SAVE_EPC.
// - MRET FSM: MRET_EPC (rd mepc, latch)
//   -> MRET_STATUS (rd mstatus; wr mstatus: MIE<=MPIE, MPIE<=1, MPP<=2'b11) -> REDIRECT.
// - REDIRECT: redirectValid=1 for exactly one cycle, then IDLE.
//   Trap target: mtvec[1:0]==2'b01 with an interrupt gives {mtvec[31:2],2'b00} + 4*cause[30:0].
//   Trap target otherwise: {mtvec[31:2],2'b00}.
//   MRET target: {mepc[31:2],2'b00}.
// - Latency, accept cycle = T0:
//   exception redirect at T5; taken interrupt redirect at T6; masked interrupt busy only at T1; MRET redirect at T3.
// - The CSR write port is driven only in the write states listed above; csrDestinationEnable=0 in every other busy state.
// - Requests arriving while busy are ignored; the pipeline holds them because busy stalls it.
// - The interrupt line is re-sampled only on return to IDLE.
// - Arithmetic: 32-bit, wraps modulo 2^32; vector offset uses cause[30:0]<<2, truncated.
// TESTING
// - Passthrough, IDLE: inst write idx 4'hA data 32'h55 -> same-cycle csrDestinationEnable=1, destinationCSR=A, csrWriteData=55.
// - Exception: trapRequest, trapPC=32'h100, cause=2, value=32'hDEAD, mstatus=32'h1808, mtvec=32'h40000100.
//   -> Writes mepc=100, mcause=2, mtval=DEAD, mstatus=32'h1880 on T1..T4.
//   -> redirectPC=32'h40000100 at T5; busy high T1..T5.
// - Vectored interrupt: mtvec=32'h40000101, MIE=1, interrupt high.
//   -> mcause=32'h8000000B, mtval=0, redirectPC=32'h4000012C at T6.
// - Masked interrupt: MIE=0, interrupt high -> busy at T1 only, no CSR write, no redirect.
// - MRET: mepc=32'h204, mstatus=32'h1880 -> mstatus written 32'h1888 at T2, redirectPC=32'h204 at T3.
// - Priority/abort: trapRequest, mretRequest and an inst write in the same cycle -> exception path, inst write dropped.
//   Reset asserted at SAVE_CAUSE -> IDLE next cycle, no mtval or mstatus write, no redirect.

Source files
------------

// File: rtl/csr_trap_sequencer.sv
// Owns the CSR file's single read/write port: passes pipeline CSR accesses through when idle,
// and sequences machine trap entry (exception / interrupt) and MRET return through the write port.
module csr_trap_sequencer #(
  parameter logic [3:0]  MSTATUS_IDX = 4'h0,
  parameter logic [3:0]  MTVEC_IDX   = 4'h8,
  parameter logic [3:0]  MEPC_IDX    = 4'h9,
  parameter logic [3:0]  MCAUSE_IDX  = 4'hA,
  parameter logic [3:0]  MTVAL_IDX   = 4'hB,
  parameter logic [31:0] INT_CAUSE   = 32'h8000000B
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        trapRequest,
  input  logic [31:0] trapCause,
  input  logic [31:0] trapPC,
  input  logic [31:0] trapValue,
  input  logic        interrupt,
  input  logic        mretRequest,
  input  logic        instCsrWriteEnable,
  input  logic [3:0]  instCsrDestination,
  input  logic [31:0] instCsrWriteData,
  input  logic [3:0]  instCsrReadSel,
  output logic [31:0] instCsrReadData,
  output logic [3:0]  destinationCSR,
  output logic [3:0]  readCSR,
  output logic [31:0] csrWriteData,
  output logic        csrDestinationEnable,
  input  logic [31:0] csrReadData,
  output logic        busy,
  output logic        redirectValid,
  output logic [31:0] redirectPC,
  output logic [3:0]  o_dbg_state
);

  typedef enum logic [3:0] {
    S_IDLE        = 4'd0,
    S_INT_CHECK   = 4'd1,
    S_SAVE_EPC    = 4'd2,
    S_SAVE_CAUSE  = 4'd3,
    S_SAVE_TVAL   = 4'd4,
    S_SET_STATUS  = 4'd5,
    S_REDIRECT    = 4'd6,
    S_MRET_EPC    = 4'd7,
    S_MRET_STATUS = 4'd8
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_cause;
  logic [31:0] r_value;
  logic        r_is_int;
  logic [31:0] r_status;
  logic [31:0] r_redirect_pc;

  logic        w_accept;
  logic [31:0] w_trap_status;
  logic [31:0] w_mret_status;
  logic [31:0] w_vec_base;
  logic [31:0] w_trap_target;
  logic        w_we;
  logic        w_rv;
  logic [3:0]  w_dest;
  logic [3:0]  w_rsel;
  logic [31:0] w_wdata;

  assign w_accept = trapRequest | mretRequest | interrupt;

  // Trap entry: MPIE<=MIE, MIE<=0, MPP<=M. MRET: MIE<=MPIE, MPIE<=1, MPP<=M.
  assign w_trap_status = {r_status[31:13], 2'b11, r_status[10:8], r_status[3],
                          r_status[6:4], 1'b0, r_status[2:0]};
  assign w_mret_status = {csrReadData[31:13], 2'b11, csrReadData[10:8], 1'b1,
                          csrReadData[6:4], csrReadData[7], csrReadData[2:0]};

  // csrReadData holds mtvec while in SET_STATUS; vectoring applies to interrupts only.
  assign w_vec_base    = {csrReadData[31:2], 2'b00};
  assign w_trap_target = (r_is_int && csrReadData[1:0] == 2'b01)
                         ? w_vec_base + {r_cause[29:0], 2'b00}
                         : w_vec_base;

  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next_state;
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (trapRequest)      w_next_state = S_SAVE_EPC;
        else if (mretRequest) w_next_state = S_MRET_EPC;
        else if (interrupt)   w_next_state = S_INT_CHECK;
      end
      S_INT_CHECK:   w_next_state = csrReadData[3] ? S_SAVE_EPC : S_IDLE;
      S_SAVE_EPC:    w_next_state = S_SAVE_CAUSE;
      S_SAVE_CAUSE:  w_next_state = S_SAVE_TVAL;
      S_SAVE_TVAL:   w_next_state = S_SET_STATUS;
      S_SET_STATUS:  w_next_state = S_REDIRECT;
      S_MRET_EPC:    w_next_state = S_MRET_STATUS;
      S_MRET_STATUS: w_next_state = S_REDIRECT;
      S_REDIRECT:    w_next_state = S_IDLE;
      default:       w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_pc          <= '0;
      r_cause       <= '0;
      r_value       <= '0;
      r_is_int      <= 1'b0;
      r_status      <= '0;
      r_redirect_pc <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (trapRequest) begin
            r_pc     <= trapPC;
            r_cause  <= trapCause;
            r_value  <= trapValue;
            r_is_int <= 1'b0;
          end else if (mretRequest) begin
            r_is_int <= 1'b0;
          end else if (interrupt) begin
            r_pc     <= trapPC;
            r_cause  <= INT_CAUSE;
            r_value  <= '0;
            r_is_int <= 1'b1;
          end
        end
        S_SAVE_EPC:   r_status      <= csrReadData;
        S_SET_STATUS: r_redirect_pc <= w_trap_target;
        S_MRET_EPC:   r_redirect_pc <= {csrReadData[31:2], 2'b00};
        default: ;
      endcase
    end
  end

  always_comb begin
    w_rsel  = instCsrReadSel;
    w_dest  = instCsrDestination;
    w_wdata = instCsrWriteData;
    w_we    = 1'b0;
    w_rv    = 1'b0;
    case (r_state)
      S_IDLE:        w_we = instCsrWriteEnable & ~w_accept;
      S_INT_CHECK:   w_rsel = MSTATUS_IDX;
      S_SAVE_EPC: begin
        w_rsel  = MSTATUS_IDX;
        w_dest  = MEPC_IDX;
        w_wdata = r_pc;
        w_we    = 1'b1;
      end
      S_SAVE_CAUSE: begin
        w_dest  = MCAUSE_IDX;
        w_wdata = r_cause;
        w_we    = 1'b1;
      end
      S_SAVE_TVAL: begin
        w_dest  = MTVAL_IDX;
        w_wdata = r_value;
        w_we    = 1'b1;
      end
      S_SET_STATUS: begin
        w_rsel  = MTVEC_IDX;
        w_dest  = MSTATUS_IDX;
        w_wdata = w_trap_status;
        w_we    = 1'b1;
      end
      S_MRET_EPC:    w_rsel = MEPC_IDX;
      S_MRET_STATUS: begin
        w_rsel  = MSTATUS_IDX;
        w_dest  = MSTATUS_IDX;
        w_wdata = w_mret_status;
        w_we    = 1'b1;
      end
      S_REDIRECT:    w_rv = 1'b1;
      default: ;
    endcase
  end

  // Reset kills the write strobe and redirect in the very cycle it is asserted.
  assign csrDestinationEnable = w_we & ~reset;
  assign redirectValid        = w_rv & ~reset;
  assign destinationCSR       = w_dest;
  assign csrWriteData         = w_wdata;
  assign readCSR              = w_rsel;
  assign instCsrReadData      = csrReadData;
  assign busy                 = (r_state != S_IDLE);
  assign redirectPC           = r_redirect_pc;
  assign o_dbg_state          = r_state;

endmodule

// File: tb/tb_csr_trap_sequencer.sv
// Bench for csr_trap_sequencer: emulates the CSR file, predicts every cycle of each
// trap / MRET / passthrough from the architectural rules, and checks the DUT each cycle.
module tb_csr_trap_sequencer;

  localparam logic [3:0]  MSTATUS = 4'h0;
  localparam logic [3:0]  MTVEC   = 4'h8;
  localparam logic [3:0]  MEPC    = 4'h9;
  localparam logic [3:0]  MCAUSE  = 4'hA;
  localparam logic [3:0]  MTVAL   = 4'hB;
  localparam logic [31:0] INT_C   = 32'h8000000B;

  logic        clock;
  logic        reset;
  logic        trapRequest;
  logic [31:0] trapCause;
  logic [31:0] trapPC;
  logic [31:0] trapValue;
  logic        interrupt;
  logic        mretRequest;
  logic        instCsrWriteEnable;
  logic [3:0]  instCsrDestination;
  logic [31:0] instCsrWriteData;
  logic [3:0]  instCsrReadSel;
  logic [31:0] instCsrReadData;
  logic [3:0]  destinationCSR;
  logic [3:0]  readCSR;
  logic [31:0] csrWriteData;
  logic        csrDestinationEnable;
  logic [31:0] csrReadData;
  logic        busy;
  logic        redirectValid;
  logic [31:0] redirectPC;
  logic [3:0]  dbg_state;

  csr_trap_sequencer dut (
    .clock(clock), .reset(reset),
    .trapRequest(trapRequest), .trapCause(trapCause), .trapPC(trapPC), .trapValue(trapValue),
    .interrupt(interrupt), .mretRequest(mretRequest),
    .instCsrWriteEnable(instCsrWriteEnable), .instCsrDestination(instCsrDestination),
    .instCsrWriteData(instCsrWriteData), .instCsrReadSel(instCsrReadSel),
    .instCsrReadData(instCsrReadData), .destinationCSR(destinationCSR), .readCSR(readCSR),
    .csrWriteData(csrWriteData), .csrDestinationEnable(csrDestinationEnable),
    .csrReadData(csrReadData), .busy(busy), .redirectValid(redirectValid),
    .redirectPC(redirectPC), .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  // ---------------- CSR file emulation ----------------
  logic [31:0] csr_file [16];
  assign csrReadData = csr_file[readCSR];
  always @(posedge clock) begin
    if (csrDestinationEnable) csr_file[destinationCSR] <= csrWriteData;
  end

  // ---------------- model state / scoreboard ----------------
  logic [31:0] m_csr [16];

  typedef struct packed {
    logic        busy;
    logic        we;
    logic [3:0]  dest;
    logic [31:0] data;
    logic        rv;
    logic [31:0] rpc;
    logic        rd_care;
    logic [31:0] rdata;
  } exp_t;
  exp_t exp_q[$];
  exp_t cmp_e;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cnt = 0;
  int rv_cnt   = 0;
  int wr_cnt   = 0;
  logic [31:0] last_rpc = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: actual %h required %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic push(input logic b, input logic we, input logic [3:0] d, input logic [31:0] dat,
                      input logic rv, input logic [31:0] rpc, input logic rc, input logic [31:0] rd);
    exp_t e;
    e.busy = b; e.we = we; e.dest = d; e.data = dat;
    e.rv = rv; e.rpc = rpc; e.rd_care = rc; e.rdata = rd;
    exp_q.push_back(e);
  endtask

  always @(negedge clock) begin
    if (busy) busy_cnt++;
    if (redirectValid) begin
      rv_cnt++;
      last_rpc = redirectPC;
    end
    if (csrDestinationEnable) wr_cnt++;
    if (exp_q.size() != 0) begin
      cmp_e = exp_q.pop_front();
      check("busy", {31'd0, busy}, {31'd0, cmp_e.busy});
      check("wr_en", {31'd0, csrDestinationEnable}, {31'd0, cmp_e.we});
      if (cmp_e.we) begin
        check("wr_idx", {28'd0, destinationCSR}, {28'd0, cmp_e.dest});
        check("wr_data", csrWriteData, cmp_e.data);
      end
      check("redirect_valid", {31'd0, redirectValid}, {31'd0, cmp_e.rv});
      if (cmp_e.rv) check("redirect_pc", redirectPC, cmp_e.rpc);
      if (cmp_e.rd_care) check("read_data", instCsrReadData, cmp_e.rdata);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    trapRequest = 1'b0; interrupt = 1'b0; mretRequest = 1'b0;
    instCsrWriteEnable = 1'b0; instCsrDestination = 4'h0; instCsrWriteData = '0;
    instCsrReadSel = 4'h0;
  endtask

  task automatic idle(input logic we, input logic [3:0] d, input logic [31:0] dat, input logic [3:0] rs);
    quiet();
    instCsrWriteEnable = we; instCsrDestination = d; instCsrWriteData = dat; instCsrReadSel = rs;
    push(1'b0, we, d, dat, 1'b0, '0, 1'b1, m_csr[rs]);
    if (we) m_csr[d] = dat;
    tick();
  endtask

  // Trap entry (exception or interrupt). noise drives competing requests and inst writes
  // throughout; abort_at selects the write step (0..3) at which reset is pulsed, -1 for none.
  task automatic run_trap(input bit is_int, input logic [31:0] pc, input logic [31:0] cause,
                          input logic [31:0] val, input bit noise, input int abort_at);
    logic [31:0] s, st, tv, tgt, c, v;
    logic [3:0]  didx [4];
    logic [31:0] ddat [4];
    trapRequest = !is_int; interrupt = is_int | noise; mretRequest = noise;
    trapPC = pc; trapCause = cause; trapValue = val;
    instCsrWriteEnable = noise; instCsrDestination = 4'h5; instCsrWriteData = 32'h77;
    instCsrReadSel = 4'h0;
    push(1'b0, 1'b0, 4'h0, '0, 1'b0, '0, 1'b1, m_csr[0]);
    tick();
    trapRequest = 1'b0; interrupt = 1'b0; mretRequest = noise;
    trapPC = 32'hFFFF_FFF0; trapCause = 32'h1111_1111; trapValue = 32'h2222_2222;
    instCsrWriteData = 32'hBAD0_0000;
    c = is_int ? INT_C : cause;
    v = is_int ? 32'h0 : val;
    if (is_int) begin
      push(1'b1, 1'b0, 4'h0, '0, 1'b0, '0, 1'b0, '0);
      tick();
      if (!m_csr[MSTATUS][3]) begin
        quiet();
        return;
      end
    end
    s = m_csr[MSTATUS];
    st = s; st[7] = s[3]; st[3] = 1'b0; st[12:11] = 2'b11;
    tv = m_csr[MTVEC];
    tgt = {tv[31:2], 2'b00};
    if (is_int && tv[1:0] == 2'b01) tgt = tgt + (c << 2);
    didx[0] = MEPC;    ddat[0] = pc;
    didx[1] = MCAUSE;  ddat[1] = c;
    didx[2] = MTVAL;   ddat[2] = v;
    didx[3] = MSTATUS; ddat[3] = st;
    for (int k = 0; k < 4; k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        push(1'b1, 1'b0, 4'h0, '0, 1'b0, '0, 1'b0, '0);
        tick();
        reset = 1'b0;
        quiet();
        return;
      end
      push(1'b1, 1'b1, didx[k], ddat[k], 1'b0, '0, 1'b0, '0);
      m_csr[didx[k]] = ddat[k];
      tick();
    end
    push(1'b1, 1'b0, 4'h0, '0, 1'b1, tgt, 1'b0, '0);
    tick();
    quiet();
  endtask

  task automatic run_mret();
    logic [31:0] s, st, ep;
    quiet();
    mretRequest = 1'b1;
    instCsrWriteEnable = 1'b1; instCsrDestination = 4'h6; instCsrWriteData = 32'h99;
    push(1'b0, 1'b0, 4'h0, '0, 1'b0, '0, 1'b1, m_csr[0]);
    tick();
    quiet();
    push(1'b1, 1'b0, 4'h0, '0, 1'b0, '0, 1'b0, '0);
    tick();
    s = m_csr[MSTATUS];
    st = s; st[3] = s[7]; st[7] = 1'b1; st[12:11] = 2'b11;
    ep = m_csr[MEPC];
    push(1'b1, 1'b1, MSTATUS, st, 1'b0, '0, 1'b0, '0);
    m_csr[MSTATUS] = st;
    tick();
    push(1'b1, 1'b0, 4'h0, '0, 1'b1, {ep[31:2], 2'b00}, 1'b0, '0);
    tick();
  endtask

  // ---------------- main sequence ----------------
  int b0, r0, w0;

  task automatic snap();
    b0 = busy_cnt; r0 = rv_cnt; w0 = wr_cnt;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) begin
      csr_file[i] = '0;
      m_csr[i] = '0;
    end
    quiet();
    reset = 1'b1;
    instCsrWriteEnable = 1'b1; instCsrDestination = MCAUSE; instCsrWriteData = 32'hFFFF;
    tick();
    tick();
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_redirect_valid", {31'd0, redirectValid}, 32'd0);
    check("reset_redirect_pc", redirectPC, 32'd0);
    check("reset_wr_en", {31'd0, csrDestinationEnable}, 32'd0);
    reset = 1'b0;
    quiet();

    // passthrough
    idle(1'b1, MCAUSE, 32'h55, MCAUSE);
    idle(1'b0, 4'h0, '0, MCAUSE);
    check("pass_mcause", csr_file[MCAUSE], 32'h55);

    // exception
    idle(1'b1, MSTATUS, 32'h1808, 4'h0);
    idle(1'b1, MTVEC, 32'h40000100, 4'h0);
    snap();
    run_trap(1'b0, 32'h100, 32'h2, 32'hDEAD, 1'b0, -1);
    idle(1'b0, 4'h0, '0, MEPC);
    check("exc_mepc", csr_file[MEPC], 32'h100);
    check("exc_mcause", csr_file[MCAUSE], 32'h2);
    check("exc_mtval", csr_file[MTVAL], 32'hDEAD);
    check("exc_mstatus", csr_file[MSTATUS], 32'h1880);
    check("exc_target", last_rpc, 32'h40000100);
    check("exc_busy_cycles", busy_cnt - b0, 32'd5);

    // vectored interrupt
    idle(1'b1, MTVEC, 32'h40000101, 4'h0);
    idle(1'b1, MSTATUS, 32'h1808, 4'h0);
    snap();
    run_trap(1'b1, 32'h300, 32'h0, 32'h0, 1'b0, -1);
    idle(1'b0, 4'h0, '0, 4'h0);
    check("int_mcause", csr_file[MCAUSE], 32'h8000000B);
    check("int_mtval", csr_file[MTVAL], 32'h0);
    check("int_mepc", csr_file[MEPC], 32'h300);
    check("int_target", last_rpc, 32'h4000012C);
    check("int_busy_cycles", busy_cnt - b0, 32'd6);

    // masked interrupt (MIE cleared by the previous trap)
    snap();
    run_trap(1'b1, 32'h600, 32'h0, 32'h0, 1'b0, -1);
    idle(1'b0, 4'h0, '0, 4'h0);
    check("mask_busy_cycles", busy_cnt - b0, 32'd1);
    check("mask_writes", wr_cnt - w0, 32'd0);
    check("mask_redirects", rv_cnt - r0, 32'd0);
    check("mask_mepc", csr_file[MEPC], 32'h300);

    // MRET
    idle(1'b1, MEPC, 32'h204, 4'h0);
    snap();
    run_mret();
    idle(1'b0, 4'h0, '0, 4'h0);
    check("mret_mstatus", csr_file[MSTATUS], 32'h1888);
    check("mret_target", last_rpc, 32'h204);
    check("mret_busy_cycles", busy_cnt - b0, 32'd3);
    check("mret_inst_dropped", csr_file[4'h6], 32'h0);
    idle(1'b1, MEPC, 32'h20B, 4'h0);
    run_mret();
    idle(1'b0, 4'h0, '0, 4'h0);
    check("mret_align_target", last_rpc, 32'h208);

    // priority: exception beats MRET, interrupt and an inst write
    snap();
    run_trap(1'b0, 32'h400, 32'h3, 32'hCAFE, 1'b1, -1);
    idle(1'b0, 4'h0, '0, 4'h0);
    check("prio_target", last_rpc, 32'h40000100);
    check("prio_inst_dropped", csr_file[4'h5], 32'h0);
    check("prio_mcause", csr_file[MCAUSE], 32'h3);
    check("prio_mstatus", csr_file[MSTATUS], 32'h1880);
    check("prio_busy_cycles", busy_cnt - b0, 32'd5);

    // reset during SAVE_CAUSE
    snap();
    run_trap(1'b0, 32'h500, 32'h7, 32'h1234, 1'b0, 1);
    idle(1'b0, 4'h0, '0, MCAUSE);
    check("abort_mepc_kept", csr_file[MEPC], 32'h500);
    check("abort_mcause", csr_file[MCAUSE], 32'h3);
    check("abort_mtval", csr_file[MTVAL], 32'hCAFE);
    check("abort_mstatus", csr_file[MSTATUS], 32'h1880);
    check("abort_redirects", rv_cnt - r0, 32'd0);
    check("abort_busy_cycles", busy_cnt - b0, 32'd2);
    check("abort_redirect_pc", redirectPC, 32'h0);

    idle(1'b1, 4'h3, 32'h1234_5678, 4'h3);
    idle(1'b0, 4'h0, '0, 4'h3);
    check("model_vs_file", csr_file[4'h3], m_csr[4'h3]);
    tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
